// File: rtl/rsa_keygen_iterative.sv
// rsa_keygen_iterative: sequential RSA key generator (n, phi, odd-e search, extended-Euclid inverse)
module rsa_keygen_iterative #(
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st,
  input  logic [SIZE-1:0]   p,
  input  logic [SIZE-1:0]   q,
  input  logic [SIZE-1:0]   e_start,
  output logic [2*SIZE-1:0] n,
  output logic [SIZE-1:0]   e,
  output logic [2*SIZE-1:0] d,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int W2 = 2 * SIZE;
  localparam int TW = 2 * SIZE + 2;

  typedef enum logic [2:0] {IDLE, LOAD, INIT, EUCLID, CHECK, DONE} state_t;

  state_t             state_q, state_d;
  logic [SIZE-1:0]    p_q, p_d, q_q, q_d, ec_q, ec_d, e_q, e_d;
  logic [W2-1:0]      nr_q, nr_d, phi_q, phi_d, r0_q, r0_d, r1_q, r1_d, n_q, n_d, d_q, d_d;
  logic signed [TW-1:0] t0_q, t0_d, t1_q, t1_d;
  logic               bad_q, bad_d, err_q, err_d;

  logic [SIZE-1:0]    e_odd, ec_init, pm1, qm1;
  logic [W2-1:0]      qt;
  logic [SIZE:0]      e_next;
  logic signed [TW-1:0] t_next, d_fix;

  assign n    = n_q;
  assign e    = e_q;
  assign d    = d_q;
  assign err  = err_q;
  assign done = state_q == DONE;
  assign busy = state_q != IDLE && state_q != DONE;

  assign e_odd   = e_start | SIZE'(1);
  assign ec_init = e_odd < SIZE'(3) ? SIZE'(3) : e_odd;
  assign pm1     = p_q - SIZE'(1);
  assign qm1     = q_q - SIZE'(1);
  assign qt      = r1_q == '0 ? '0 : r0_q / r1_q;
  assign t_next  = t0_q - $signed({2'b00, qt}) * t1_q;
  assign d_fix   = t0_q < 0 ? t0_q + $signed({2'b00, phi_q}) : t0_q;
  assign e_next  = {1'b0, ec_q} + (SIZE+1)'(2);

  // State and datapath registers; reset aborts everything and clears outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      p_q <= '0; q_q <= '0; ec_q <= '0; e_q <= '0;
      nr_q <= '0; phi_q <= '0; r0_q <= '0; r1_q <= '0; n_q <= '0; d_q <= '0;
      t0_q <= '0; t1_q <= '0;
      bad_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q <= p_d; q_q <= q_d; ec_q <= ec_d; e_q <= e_d;
      nr_q <= nr_d; phi_q <= phi_d; r0_q <= r0_d; r1_q <= r1_d; n_q <= n_d; d_q <= d_d;
      t0_q <= t0_d; t1_q <= t1_d;
      bad_q <= bad_d; err_q <= err_d;
    end
  end

  // Next-state logic: bad p/q is flagged in LOAD and reported from INIT alongside e >= phi
  always_comb begin
    state_d = state_q;
    p_d = p_q; q_d = q_q; ec_d = ec_q; e_d = e_q;
    nr_d = nr_q; phi_d = phi_q; r0_d = r0_q; r1_d = r1_q; n_d = n_q; d_d = d_q;
    t0_d = t0_q; t1_d = t1_q;
    bad_d = bad_q; err_d = err_q;
    case (state_q)
      IDLE, DONE: if (st) begin
        p_d = p; q_d = q; ec_d = ec_init; err_d = 1'b0; state_d = LOAD;
      end
      LOAD: begin
        nr_d  = W2'(p_q) * W2'(q_q);
        phi_d = W2'(pm1) * W2'(qm1);
        bad_d = p_q < SIZE'(3) || q_q < SIZE'(3) || p_q == q_q;
        state_d = INIT;
      end
      INIT: if (bad_q || W2'(ec_q) >= phi_q) begin
        err_d = 1'b1; n_d = '0; e_d = '0; d_d = '0; state_d = DONE;
      end else begin
        r0_d = phi_q; r1_d = W2'(ec_q); t0_d = '0; t1_d = TW'(1); state_d = EUCLID;
      end
      EUCLID: if (r1_q == '0) state_d = CHECK;
      else begin
        r0_d = r1_q; r1_d = r0_q - qt * r1_q; t0_d = t1_q; t1_d = t_next;
      end
      CHECK: if (r0_q == W2'(1)) begin
        e_d = ec_q; d_d = d_fix[W2-1:0]; n_d = nr_q; state_d = DONE;
      end else if (e_next[SIZE]) begin
        err_d = 1'b1; n_d = '0; e_d = '0; d_d = '0; state_d = DONE;
      end else begin
        ec_d = e_next[SIZE-1:0]; state_d = INIT;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rsa_keygen_iterative.sv
// tb_rsa_keygen_iterative: scoreboard bench for the iterative RSA key generator
module tb_rsa_keygen_iterative;
  localparam int SZ = 16;

  typedef struct {
    longint n, e, d, phi;
    bit     err;
    int     lat;
    int     start;
  } exp_t;

  logic clk = 1'b0, reset = 1'b1, st = 1'b0;
  logic [SZ-1:0] p = '0, q = '0, e_start = '0;
  logic [2*SZ-1:0] n, d;
  logic [SZ-1:0] e;
  logic busy, done, err;
  int checks = 0, failures = 0, cyc = 0;
  exp_t sb[$];
  bit dprev = 1'b0;

  rsa_keygen_iterative #(.SIZE(SZ)) dut (
    .clk(clk), .reset(reset), .st(st), .p(p), .q(q), .e_start(e_start),
    .n(n), .e(e), .d(d), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  function automatic longint gcd(input longint a, input longint b);
    longint t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  function automatic void model(input int pp, input int qq, input int es,
                                output exp_t x);
    longint ec;
    x.n = 0; x.e = 0; x.d = 0; x.err = 1'b1; x.lat = -1;
    x.phi = longint'(pp - 1) * longint'(qq - 1);
    ec = es | 1;
    if (ec < 3) ec = 3;
    if (pp < 3 || qq < 3 || pp == qq) return;
    forever begin
      if (ec >= x.phi) return;
      if (gcd(ec, x.phi) == 1) break;
      if (ec + 2 > (1 << SZ) - 1) return;
      ec += 2;
    end
    for (longint k = 1; k < x.phi; k++)
      if ((ec * k) % x.phi == 1) begin x.d = k; break; end
    x.n = longint'(pp) * longint'(qq);
    x.e = ec;
    x.err = 1'b0;
  endfunction

  task automatic wait_done();
    for (int i = 0; i < 400 && !done; i++) @(negedge clk);
    if (!done) begin
      checks++; failures++;
      $display("FAIL timeout got=done_low want=done_high");
    end
  endtask

  task automatic issue(input int pp, input int qq, input int es, input exp_t x, input bit push);
    @(negedge clk);
    p = SZ'(pp); q = SZ'(qq); e_start = SZ'(es); st = 1'b1;
    x.start = cyc;
    if (push) sb.push_back(x);
    @(negedge clk);
    st = 1'b0;
  endtask

  task automatic run(input int pp, input int qq, input int es, input longint xn, input longint xe,
                     input longint xd, input bit xerr, input longint xphi, input int lat);
    exp_t x;
    x.n = xn; x.e = xe; x.d = xd; x.err = xerr; x.phi = xphi; x.lat = lat; x.start = 0;
    issue(pp, qq, es, x, 1'b1);
    wait_done();
  endtask

  // Monitor: pops the scoreboard on each rising done and checks busy/done exclusivity
  always @(negedge clk) begin
    exp_t x;
    if (busy) begin
      checks++;
      if (done) begin failures++; $display("FAIL overlap got=busy_and_done want=exclusive"); end
    end
    if (done && !dprev) begin
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done got=done want=no_pending_request");
      end else begin
        x = sb.pop_front();
        chk("n", longint'(n), x.n);
        chk("e", longint'(e), x.e);
        chk("d", longint'(d), x.d);
        chk("err", longint'(err), longint'(x.err));
        if (x.lat >= 0) chk("latency", longint'(cyc - x.start - 1), longint'(x.lat));
        if (!x.err) chk("inverse", (longint'(e) * longint'(d)) % x.phi, 1);
      end
    end
    dprev = done;
  end

  int primes[] = '{3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61, 67, 71,
                   73, 79, 83, 89, 97, 101, 103, 107, 109, 113, 127, 131, 137, 139, 149,
                   151, 157, 163, 167, 173, 179, 181, 191, 193, 197, 199, 211, 223, 227,
                   229, 233, 239, 241, 251};

  initial begin
    exp_t x;
    int i, j, es;
    repeat (2) @(negedge clk);
    chk("rst_n", longint'(n), 0);
    chk("rst_e", longint'(e), 0);
    chk("rst_d", longint'(d), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_err", longint'(err), 0);
    reset = 1'b0;
    run(11, 13, 7, 143, 7, 103, 0, 120, 6);
    run(11, 13, 3, 143, 7, 103, 0, 120, 14);
    run(5, 7, 4, 35, 5, 5, 0, 24, 7);
    x.n = 0; x.e = 0; x.d = 0; x.err = 0; x.phi = 0; x.lat = -1; x.start = 0;
    issue(11, 13, 7, x, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_n", longint'(n), 0);
    chk("abort_e", longint'(e), 0);
    chk("abort_d", longint'(d), 0);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    chk("abort_err", longint'(err), 0);
    @(negedge clk) reset = 1'b0;
    run(11, 13, 7, 143, 7, 103, 0, 120, 6);
    run(7, 7, 5, 0, 0, 0, 1, 36, 2);
    run(11, 13, 201, 0, 0, 0, 1, 120, 2);
    x.n = 143; x.e = 7; x.d = 103; x.err = 0; x.phi = 120; x.lat = 6;
    issue(11, 13, 7, x, 1'b1);
    @(negedge clk);
    p = SZ'(5); q = SZ'(7); e_start = SZ'(3); st = 1'b1;
    @(negedge clk) st = 1'b0;
    wait_done();
    run(61, 53, 17, 3233, 17, 2753, 0, 3120, 8);
    for (int k = 0; k < 4; k++) begin
      i = $urandom_range(0, primes.size() - 1);
      j = (i + $urandom_range(1, primes.size() - 1)) % primes.size();
      es = $urandom_range(0, 40);
      model(primes[i], primes[j], es, x);
      run(primes[i], primes[j], es, x.n, x.e, x.d, x.err, x.phi, -1);
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rsa_keygen_iterative.md
# rsa_keygen_iterative

Parametrised, fully sequential RSA key generator that succeeds the fixed-width combinational key path. It accepts primes p and q and a starting public-exponent candidate, then computes n = p·q and phi = (p−1)(q−1). It searches upward through odd e until gcd(e, phi) = 1 and derives d = e⁻¹ mod phi with a one-step-per-cycle extended Euclid engine. It sits between the prime source and the encrypt/decrypt datapath, using the same st/done handshake.

## Interface
- SIZE, 8, bit width of p, q, e_start and e; n, phi and d are 2·SIZE bits
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces IDLE and zeroes all outputs
- st  in  1  start request, sampled only in IDLE or DONE
- p, q  in  SIZE  prime inputs, sampled on the st edge
- e_start  in  SIZE  first e candidate, sampled on the st edge
- n  out  2·SIZE  modulus p·q
- e  out  SIZE  chosen public exponent
- d  out  2·SIZE  private exponent, 0 < d < phi
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE, with valid n/e/d
- err  out  1  high in DONE when no key could be produced; n/e/d are 0 when err = 1

## Operation
- States: IDLE, LOAD, INIT, EUCLID, CHECK, DONE.
- IDLE / DONE with st = 1:
  - Capture p and q.
  - Capture e_cand = e_start | 1; if the result is < 3, use 3.
  - Clear done and err, then go to LOAD.
- LOAD:
  - Register n = p·q and phi = (p−1)·(q−1), both unsigned 2·SIZE.
  - If p < 3, q < 3, or p == q: set err and go to DONE.
  - Otherwise go to INIT.
- INIT:
  - If e_cand ≥ phi: set err and go to DONE.
  - Otherwise load r0 = phi, r1 = e_cand, t0 = 0, t1 = 1 and go to EUCLID.
  - t0 and t1 are signed, 2·SIZE+2 bits.
- EUCLID, per cycle:
  - If r1 == 0, go to CHECK.
  - Otherwise with qt = r0 / r1: (r0, r1) ← (r1, r0 − qt·r1) and (t0, t1) ← (t1, t0 − qt·t1).
- CHECK:
  - If r0 == 1: e ← e_cand, d ← (t0 < 0 ? t0 + phi : t0), n ← registered n, then go to DONE.
  - Else if e_cand + 2 overflows SIZE bits: set err and go to DONE.
  - Else e_cand ← e_cand + 2 and go to INIT.
- DONE:
  - Hold outputs; done = 1.
  - A new st restarts the flow as in IDLE.
- st while busy is ignored.
- p, q and e_start changing while busy have no effect.
- Primality of p and q is not checked; correctness requires prime inputs.

## Timing
- Reset values: n = 0, e = 0, d = 0, done = 0, err = 0, busy = 0, state IDLE.
- Reset asserted mid-computation aborts immediately; nothing is retained.
- st sampled at edge k; busy is high from after edge k.
- Accepted on the first candidate, with S Euclid steps: done rises after edge k + 4 + S, where S counts the non-terminal EUCLID cycles.
- Each rejected candidate adds (3 + S_i) cycles: INIT + EUCLID steps + terminal EUCLID + CHECK.
- Error in LOAD: done and err high after edge k+2.
- Error in INIT: done and err high one cycle after that INIT.
- done and busy are never high together.
- done stays high until the edge that accepts the next st, or until reset.
- Outputs change only on the edge that enters DONE or on reset.

## Test plan
- p=11, q=13, e_start=7 → n=143, e=7, d=103, err=0; done exactly 6 cycles after st (S=2).
- p=11, q=13, e_start=3 → candidates 3 and 5 rejected (gcd 3 and 5); result e=7, d=103, n=143.
- p=5, q=7, e_start=4 → e_cand forced to 5; n=35, e=5, d=5.
- Error cases:
  - p=q=7 → err=1, done=1 two cycles after st, n=e=d=0.
  - p=11, q=13, e_start=201 with SIZE=8 → 201 ≥ 120 → err=1.
- Reset and restart:
  - Assert reset mid-EUCLID → all outputs 0 and state IDLE asynchronously.
  - Rerun p=11, q=13, e_start=7 → identical result and latency.
  - st pulses during busy are ignored.
- SIZE=16, p=61, q=53, e_start=17 → n=3233, e=17, d=2753; randomized prime pairs checked against the reference model: e·d mod phi == 1.
